// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the BCD step counter slice.
//   nibble_t    : 4-bit digit carried between the counter, comparator and
//                 hex decoder.
//   BCD_MAX     : default highest digit value (decimal 9).
//   deb_state_t : push-button debouncer states.
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Cleans a raw active-low push-button into single-cycle step strobes.
// A 2-flop synchronizer feeds a four-state debounce FSM; a press is accepted
// once the synchronized key has been steady for DEBOUNCE_CYCLES cycles, and
// a release must be equally steady before the next press can count.
//
// Optional feature (macro HOLD_REPEAT_EN): while the key is held, a step is
// repeated every REPEAT_CYCLES cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (already release-synchronized)
//   key_n      in   raw active-low push-button, asynchronous to clk
//   step       out  one-cycle step strobe
//   key_stable out  high while the FSM is in IDLE or HELD
// -----------------------------------------------------------------------------
module key_debouncer
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic step,
  output logic key_stable
);

  localparam int SPAN  = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(SPAN) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       sync;
  logic [1:0]       fill;    // tracks when sync[1] holds a real sample
  logic             armed;   // a genuine release has been seen since reset
  logic             key;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours (shift chain works).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      fill  <= 2'b00;
      armed <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], key_n};
      fill  <= {fill[0], 1'b1};
      // A key held through reset reads as released until the synchronizer
      // fills, so only a release seen after that point arms the stepping.
      if (fill[1] && !key)
        armed <= 1'b1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign key = ~sync[1];

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (key) begin
          cnt_nxt = '0;
          // Unarmed (held through reset): skip straight to HELD without a
          // step, so the key must be released before it can step again.
          state_nxt = armed ? PRESS_WAIT : HELD;
        end
      end
      PRESS_WAIT: begin
        if (!key) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          step      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE_WAIT;
        end else begin
`ifdef HOLD_REPEAT_EN
          if (cnt == RPT_LAST) begin
            step    = armed;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (key) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_stable = (state == IDLE) || (state == HELD);

endmodule

// File: rtl/bcd_step_counter.sv
// -----------------------------------------------------------------------------
// bcd_step_counter
// Debounced push-button stepping of a single BCD digit, with decimal wrap,
// carry/borrow pulse and a synchronous load. COUNT feeds the nibble
// comparator and hex decoder in place of raw switch inputs.
//
// Optional feature (macro HOLD_REPEAT_EN): auto-repeat while the key is held.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET_N     in   asynchronous active-low reset, release synchronized here
//   STEP_N      in   raw active-low push-button
//   UP          in   1 = increment, 0 = decrement
//   LOAD        in   synchronous load strobe
//   LOAD_VAL    in   value to load (clamped to MAX_COUNT, flagged by LOAD_ERR)
//   COUNT       out  current digit
//   CARRY       out  one-cycle pulse on wrap in either direction
//   LOAD_ERR    out  one-cycle pulse when LOAD_VAL > MAX_COUNT
//   KEY_STABLE  out  debouncer is in IDLE or HELD
// -----------------------------------------------------------------------------
module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_COUNT       = int'(BCD_MAX),
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       STEP_N,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [3:0] LOAD_VAL,
  output logic [3:0] COUNT,
  output logic       CARRY,
  output logic       LOAD_ERR,
  output logic       KEY_STABLE
);

  localparam nibble_t MAX_N = nibble_t'(MAX_COUNT);

  logic [1:0] rst_sync;
  logic       rst_n;
  logic       step;
  nibble_t    count;
  logic       carry;
  logic       load_err;

  // Assertion reaches every flop immediately; release is delayed two edges so
  // all state leaves reset on the same clock.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_deb (
    .clk        (CLOCK_50),
    .rst_n      (rst_n),
    .key_n      (STEP_N),
    .step       (step),
    .key_stable (KEY_STABLE)
  );

  // Load has priority over a coincident step; the step is simply dropped.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (LOAD) begin
        if (LOAD_VAL > MAX_N) begin
          count    <= MAX_N;
          load_err <= 1'b1;
        end else begin
          count <= LOAD_VAL;
        end
      end else if (step) begin
        if (UP) begin
          if (count == MAX_N) begin
            count <= '0;
            carry <= 1'b1;
          end else begin
            count <= count + 4'd1;
          end
        end else begin
          if (count == 4'd0) begin
            count <= MAX_N;
            carry <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end
      end
    end
  end

  assign COUNT    = count;
  assign CARRY    = carry;
  assign LOAD_ERR = load_err;

  count_in_range: assert property (@(posedge CLOCK_50) disable iff (!rst_n) count <= MAX_N);

endmodule
